// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter in front of one shared UART transmitter.
// Each requester has a one-byte holding slot and may lock the transmitter across several bytes.
module uart_tx_arbiter #(
  parameter int unsigned LOCK_TIMEOUT = 1_200_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_start,
  input  logic [15:0] req_data,
  input  logic [1:0]  req_lock,
  output logic [1:0]  req_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic        grant_id,
  output logic        idle
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GUARD,
    S_WAIT_DONE
  } state_e;

  localparam logic [20:0] LOCK_LAST = 21'(LOCK_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [1:0]      pend_q, pend_d;
  logic [1:0][7:0] hold_q, hold_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            grant_q, grant_d;
  logic            lock_valid_q, lock_valid_d;
  logic            lock_owner_q, lock_owner_d;
  logic [20:0]     lock_cnt_q, lock_cnt_d;

  logic            lock_eff;
  logic [1:0]      elig;
  logic            win_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pend_q       <= '0;
      hold_q       <= '0;
      tx_data_q    <= '0;
      grant_q      <= 1'b1;
      lock_valid_q <= 1'b0;
      lock_owner_q <= 1'b0;
      lock_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      hold_q       <= hold_d;
      tx_data_q    <= tx_data_d;
      grant_q      <= grant_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    hold_d       = hold_q;
    tx_data_d    = tx_data_q;
    grant_d      = grant_q;
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = '0;
    lock_eff     = 1'b0;
    elig         = '0;
    win_id       = 1'b0;

    // A strobe is only accepted into an empty slot; a winner always has pend set, so no clash.
    if (req_start[0] && !pend_q[0]) begin
      pend_d[0] = 1'b1;
      hold_d[0] = req_data[7:0];
    end
    if (req_start[1] && !pend_q[1]) begin
      pend_d[1] = 1'b1;
      hold_d[1] = req_data[15:8];
    end

    unique case (state_q)
      S_IDLE: begin
        // A dropped req_lock releases the lock in the same cycle it is seen.
        lock_eff     = lock_valid_q && req_lock[lock_owner_q];
        lock_valid_d = lock_eff;
        if (lock_eff && !pend_q[lock_owner_q]) begin
          if (lock_cnt_q == LOCK_LAST) begin
            lock_valid_d = 1'b0;
          end else begin
            lock_cnt_d = lock_cnt_q + 21'd1;
          end
        end
        if (!tx_busy) begin
          elig = lock_eff ? (pend_q & (lock_owner_q ? 2'b10 : 2'b01)) : pend_q;
          win_id = (&elig) ? ~grant_q : elig[1];
          if (|elig) begin
            tx_data_d      = hold_q[win_id];
            grant_d        = win_id;
            pend_d[win_id] = 1'b0;
            state_d        = S_ISSUE;
            if (req_lock[win_id]) begin
              lock_valid_d = 1'b1;
              lock_owner_d = win_id;
            end
          end
        end
      end
      S_ISSUE:     state_d = S_GUARD;
      S_GUARD:     state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (!tx_busy) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  assign tx_start = (state_q == S_ISSUE);
  assign tx_data  = tx_data_q;
  assign grant_id = grant_q;
  assign req_busy = pend_q | ({grant_q, ~grant_q} & {2{state_q != S_IDLE}});
  assign idle     = (pend_q == 2'b00) && (state_q == S_IDLE) && !tx_busy && !tx_start;

endmodule
